// File: rtl/pipeline_ctrl.sv
// Pipeline hazard / flow controller for a 5-stage in-order core.
//
// Ports:
//   clk, rst_n                      single clock, synchronous active-low reset
//   i_id_rs1/rs2, i_id_use1/use2    sources of the instruction in ID
//   i_exe_rs1/rs2, i_exe_rd,
//   i_exe_regwrite, i_exe_memread   instruction in EXE
//   i_mem_rd, i_mem_regwrite        EXE/MEM destination (forwarding source 01)
//   i_wb_rd, i_wb_regwrite          MEM/WB destination (forwarding source 10)
//   i_branch_taken                  branch resolved taken in EXE
//   i_mem_req, i_mem_ready          data-memory handshake of the MEM stage
//   i_halt, i_resume                halt / resume requests
//   o_pc_en, o_*_en                 PC and pipeline-register load enables
//   o_ifid_flush, o_idexe_flush     load a bubble instead of data
//   o_fwd_a, o_fwd_b                EXE operand select (00 RF, 01 EXE/MEM, 10 MEM/WB)
//   o_state, o_halted               FSM state (RUN/MEM_WAIT/DRAIN/HALTED), halted flag
//   o_mem_timeout                   sticky memory-wait timeout
//   o_stall_cnt                     count of cycles with the PC held (outside HALTED)
module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned WAIT_LIMIT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  i_id_rs1,
    input  logic [3:0]  i_id_rs2,
    input  logic        i_id_use1,
    input  logic        i_id_use2,
    input  logic [3:0]  i_exe_rs1,
    input  logic [3:0]  i_exe_rs2,
    input  logic [3:0]  i_exe_rd,
    input  logic        i_exe_regwrite,
    input  logic        i_exe_memread,
    input  logic [3:0]  i_mem_rd,
    input  logic        i_mem_regwrite,
    input  logic [3:0]  i_wb_rd,
    input  logic        i_wb_regwrite,
    input  logic        i_branch_taken,
    input  logic        i_mem_req,
    input  logic        i_mem_ready,
    input  logic        i_halt,
    input  logic        i_resume,
    output logic        o_pc_en,
    output logic        o_ifid_en,
    output logic        o_idexe_en,
    output logic        o_exemem_en,
    output logic        o_memwb_en,
    output logic        o_ifid_flush,
    output logic        o_idexe_flush,
    output logic [1:0]  o_fwd_a,
    output logic [1:0]  o_fwd_b,
    output logic [1:0]  o_state,
    output logic        o_halted,
    output logic        o_mem_timeout,
    output logic [15:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StDrain   = 2'd2,
        StHalted  = 2'd3
    } state_e;

    localparam logic [15:0] DrainInit = 16'(DRAIN_CYCLES);
    localparam logic [15:0] WaitLimit = 16'(WAIT_LIMIT);

    state_e      state_q, state_d, ret_q, ret_d, eff_state;
    logic [15:0] drain_q, drain_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] stall_q, stall_d;
    logic        timeout_q, timeout_d;

    logic freeze, load_use;
    logic pc_en, ifid_en, idexe_en, exemem_en, memwb_en;
    logic ifid_flush, idexe_flush;

    assign freeze   = i_mem_req & ~i_mem_ready;
    assign load_use = i_exe_memread & i_exe_regwrite &
                      ((i_id_use1 & (i_id_rs1 == i_exe_rd)) |
                       (i_id_use2 & (i_id_rs2 == i_exe_rd)));

    // The cycle memory becomes ready behaves as a cycle of the saved return state.
    assign eff_state = (state_q == StMemWait) ? ret_q : state_q;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        drain_d     = drain_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idexe_en    = 1'b0;
        exemem_en   = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;

        if (state_q == StMemWait) begin
            if (wait_q != 16'hFFFF) begin
                wait_d = wait_q + 16'd1;
            end
            if (wait_d >= WaitLimit) begin
                timeout_d = 1'b1;
            end
        end

        if (state_q == StMemWait && !i_mem_ready) begin
            // Everything frozen until memory answers.
        end else if ((state_q == StRun || state_q == StDrain) && freeze) begin
            state_d = StMemWait;
            ret_d   = state_q;
            wait_d  = 16'd0;
        end else begin
            if (state_q == StMemWait) begin
                state_d = ret_q;
            end
            case (eff_state)
                StRun: begin
                    pc_en     = 1'b1;
                    ifid_en   = 1'b1;
                    idexe_en  = 1'b1;
                    exemem_en = 1'b1;
                    memwb_en  = 1'b1;
                    if (i_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idexe_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idexe_flush = 1'b1;
                    end
                    if (i_halt) begin
                        drain_d = DrainInit;
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    // Fetch stops; bubbles enter IF/ID while older work retires.
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idexe_en   = 1'b1;
                    exemem_en  = 1'b1;
                    memwb_en   = 1'b1;
                    if (drain_q <= 16'd1) begin
                        drain_d = 16'd0;
                        state_d = StHalted;
                    end else begin
                        drain_d = drain_q - 16'd1;
                    end
                end
                StHalted: begin
                    if (i_resume) begin
                        state_d = StRun;
                    end
                end
                default: begin
                end
            endcase
        end

        stall_d = stall_q;
        if (!pc_en && state_q != StHalted) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StRun;
            ret_q     <= StRun;
            drain_q   <= 16'd0;
            wait_q    <= 16'd0;
            stall_q   <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            drain_q   <= drain_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    // Forwarding is purely combinational; EXE/MEM wins over MEM/WB.
    always_comb begin
        o_fwd_a = 2'b00;
        if (i_mem_regwrite && i_mem_rd == i_exe_rs1) begin
            o_fwd_a = 2'b01;
        end else if (i_wb_regwrite && i_wb_rd == i_exe_rs1) begin
            o_fwd_a = 2'b10;
        end
        o_fwd_b = 2'b00;
        if (i_mem_regwrite && i_mem_rd == i_exe_rs2) begin
            o_fwd_b = 2'b01;
        end else if (i_wb_regwrite && i_wb_rd == i_exe_rs2) begin
            o_fwd_b = 2'b10;
        end
    end

    // While reset is asserted the pipeline holds and loads bubbles.
    assign o_pc_en       = rst_n & pc_en;
    assign o_ifid_en     = rst_n & ifid_en;
    assign o_idexe_en    = rst_n & idexe_en;
    assign o_exemem_en   = rst_n & exemem_en;
    assign o_memwb_en    = rst_n & memwb_en;
    assign o_ifid_flush  = ~rst_n | ifid_flush;
    assign o_idexe_flush = ~rst_n | idexe_flush;
    assign o_state       = state_q;
    assign o_halted      = rst_n & (state_q == StHalted);
    assign o_mem_timeout = timeout_q;
    assign o_stall_cnt   = stall_q;

endmodule
